// File: rtl/sys_ctrl_mc_if.sv
// sys_ctrl_mc_if: SMI/SPI IOC register bus between the bus master and sys_ctrl_mc.
// The master drives address, write data, select and strobes; the slave returns read data.
interface sys_ctrl_mc_if;
    logic [4:0] i_ioc;
    logic [7:0] i_data_in;
    logic [7:0] o_data_out;
    logic       i_cs;
    logic       i_fetch_cmd;
    logic       i_load_cmd;

    modport master (
        output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        input  o_data_out
    );

    modport slave (
        input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        output o_data_out
    );
endinterface

// File: rtl/sys_ctrl_mc.sv
// sys_ctrl_mc: multi-channel system control register block on the IOC bus.
// Holds version/ID readback, sticky clear-on-read errors, debug mode bits, per-channel
// TX gap and sync-type configuration, and a soft-sync engine (level or timed pulse).
// Optional macro SYS_CTRL_MC_TIMESTAMP_EN adds a 32-bit free-running timestamp with a
// snapshot shadow at IOC 0x0C-0x0F; without it those addresses are unmapped.
module sys_ctrl_mc #(
    parameter int         N_CH           = 2,
    parameter int         GAP_W          = 4,
    parameter logic [7:0] MODULE_VERSION = 8'h02,
    parameter logic [7:0] SYSTEM_VERSION = 8'h01,
    parameter logic [7:0] MANU_ID        = 8'h01
) (
    input  logic                    i_rst_b,
    input  logic                    i_sys_clk,
    sys_ctrl_mc_if.slave            bus,
    input  logic [7:0]              i_err_flags,
    output logic [3:0]              o_debug_modes,
    output logic [N_CH*GAP_W-1:0]   o_tx_sample_gap,
    output logic [N_CH*2-1:0]       o_rx_sync_type,
    output logic [N_CH*2-1:0]       o_tx_sync_type,
    output logic [N_CH-1:0]         o_rx_sync,
    output logic [N_CH-1:0]         o_tx_sync,
    output logic                    o_sync_busy
);

    localparam logic [4:0] IOC_MODULE_VER = 5'h00;
    localparam logic [4:0] IOC_SYSTEM_VER = 5'h01;
    localparam logic [4:0] IOC_MANU_ID    = 5'h02;
    localparam logic [4:0] IOC_ERR        = 5'h03;
    localparam logic [4:0] IOC_DEBUG      = 5'h05;
    localparam logic [4:0] IOC_CH_SEL     = 5'h06;
    localparam logic [4:0] IOC_CH_CFG     = 5'h07;
    localparam logic [4:0] IOC_SOFT_SYNC  = 5'h08;
    localparam logic [4:0] IOC_SYNC_LEN   = 5'h09;
    localparam logic [4:0] IOC_SCRATCH    = 5'h0A;
`ifdef SYS_CTRL_MC_TIMESTAMP_EN
    localparam logic [4:0] IOC_TS0        = 5'h0C;
    localparam logic [4:0] IOC_TS1        = 5'h0D;
    localparam logic [4:0] IOC_TS2        = 5'h0E;
    localparam logic [4:0] IOC_TS3        = 5'h0F;
`endif

    logic                  fetch;
    logic                  load;
    logic [7:0]            err_q;
    logic [3:0]            debug_q;
    logic [1:0]            ch_sel_q;
    logic [N_CH*GAP_W-1:0] gap_q;
    logic [N_CH*2-1:0]     rx_type_q;
    logic [N_CH*2-1:0]     tx_type_q;
    logic [7:0]            sync_len_q;
    logic [7:0]            scratch_q;
    logic [7:0]            rd_data;
    logic [7:0]            data_out_q;
    logic                  sync_wr;
    logic [2*N_CH-1:0]     sync_trig;
    logic [2*N_CH-1:0]     sync_out_q;
    logic [7:0]            sync_cnt_q [2*N_CH];
`ifdef SYS_CTRL_MC_TIMESTAMP_EN
    logic [31:0]           ts_cnt_q;
    logic [31:0]           ts_shadow_q;
`endif

    // A fetch takes priority; a load in the same cycle is dropped.
    assign fetch   = bus.i_cs & bus.i_fetch_cmd;
    assign load    = bus.i_cs & bus.i_load_cmd & ~bus.i_fetch_cmd;
    assign sync_wr = load && (bus.i_ioc == IOC_SOFT_SYNC);

    // Writable configuration registers; ch_cfg writes land only on an existing channel.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            debug_q    <= 4'h0;
            ch_sel_q   <= 2'b00;
            gap_q      <= '0;
            rx_type_q  <= '0;
            tx_type_q  <= '0;
            sync_len_q <= 8'h00;
            scratch_q  <= 8'h00;
        end else if (load) begin
            case (bus.i_ioc)
                IOC_DEBUG:    debug_q  <= bus.i_data_in[3:0];
                IOC_CH_SEL:   ch_sel_q <= bus.i_data_in[1:0];
                IOC_CH_CFG: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (ch_sel_q == 2'(c)) begin
                            gap_q[c*GAP_W +: GAP_W] <= bus.i_data_in[GAP_W-1:0];
                            rx_type_q[2*c +: 2]     <= bus.i_data_in[5:4];
                            tx_type_q[2*c +: 2]     <= bus.i_data_in[7:6];
                        end
                    end
                end
                IOC_SYNC_LEN: sync_len_q <= bus.i_data_in;
                IOC_SCRATCH:  scratch_q  <= bus.i_data_in;
                default: ;
            endcase
        end
    end

    // Sticky error bits; a clearing fetch reloads with this cycle's flags so new events survive.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            err_q <= 8'h00;
        end else if (fetch && (bus.i_ioc == IOC_ERR)) begin
            err_q <= i_err_flags;
        end else begin
            err_q <= err_q | i_err_flags;
        end
    end

    // Map soft_sync write bits onto outputs: RX channels first, then TX channels.
    always_comb begin
        sync_trig = '0;
        for (int c = 0; c < N_CH; c++) begin
            sync_trig[c]        = bus.i_data_in[c];
            sync_trig[N_CH + c] = bus.i_data_in[4 + c];
        end
    end

    // Soft-sync engine: level mode copies the written bit, pulse mode runs a down-counter
    // that only advances while the length is nonzero, so zeroing it freezes the output.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sync_out_q <= '0;
            for (int i = 0; i < 2*N_CH; i++) sync_cnt_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 2*N_CH; i++) begin
                if (sync_wr && (sync_len_q == 8'h00)) begin
                    sync_out_q[i] <= sync_trig[i];
                    sync_cnt_q[i] <= 8'h00;
                end else if (sync_wr && sync_trig[i]) begin
                    sync_out_q[i] <= 1'b1;
                    sync_cnt_q[i] <= sync_len_q;
                end else if ((sync_len_q != 8'h00) && (sync_cnt_q[i] != 8'h00)) begin
                    sync_cnt_q[i] <= sync_cnt_q[i] - 8'd1;
                    if (sync_cnt_q[i] == 8'd1) sync_out_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SYS_CTRL_MC_TIMESTAMP_EN
    // Free-running timestamp, zeroed by a load of TS0; a fetch of TS0 captures the shadow.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            ts_cnt_q    <= 32'h0;
            ts_shadow_q <= 32'h0;
        end else begin
            if (load && (bus.i_ioc == IOC_TS0)) ts_cnt_q <= 32'h0;
            else                                ts_cnt_q <= ts_cnt_q + 32'd1;
            if (fetch && (bus.i_ioc == IOC_TS0)) ts_shadow_q <= ts_cnt_q;
        end
    end
`endif

    // Read mux; unmapped and write-only addresses return zero.
    always_comb begin
        rd_data = 8'h00;
        case (bus.i_ioc)
            IOC_MODULE_VER: rd_data = MODULE_VERSION;
            IOC_SYSTEM_VER: rd_data = SYSTEM_VERSION;
            IOC_MANU_ID:    rd_data = MANU_ID;
            IOC_ERR:        rd_data = err_q;
            IOC_DEBUG:      rd_data = {4'h0, debug_q};
            IOC_CH_SEL:     rd_data = {6'h00, ch_sel_q};
            IOC_CH_CFG: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_sel_q == 2'(c)) begin
                        rd_data[GAP_W-1:0] = gap_q[c*GAP_W +: GAP_W];
                        rd_data[5:4]       = rx_type_q[2*c +: 2];
                        rd_data[7:6]       = tx_type_q[2*c +: 2];
                    end
                end
            end
            IOC_SYNC_LEN:   rd_data = sync_len_q;
            IOC_SCRATCH:    rd_data = scratch_q;
`ifdef SYS_CTRL_MC_TIMESTAMP_EN
            IOC_TS0:        rd_data = ts_cnt_q[7:0];
            IOC_TS1:        rd_data = ts_shadow_q[15:8];
            IOC_TS2:        rd_data = ts_shadow_q[23:16];
            IOC_TS3:        rd_data = ts_shadow_q[31:24];
`endif
            default:        rd_data = 8'h00;
        endcase
    end

    // Registered read data, updated only by a fetch and held otherwise.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b)   data_out_q <= 8'h00;
        else if (fetch) data_out_q <= rd_data;
    end

    assign bus.o_data_out  = data_out_q;
    assign o_debug_modes   = debug_q;
    assign o_tx_sample_gap = gap_q;
    assign o_rx_sync_type  = rx_type_q;
    assign o_tx_sync_type  = tx_type_q;
    assign o_rx_sync       = sync_out_q[N_CH-1:0];
    assign o_tx_sync       = sync_out_q[2*N_CH-1:N_CH];
    assign o_sync_busy     = |sync_out_q;

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// tb_sys_ctrl_mc: self-checking bench for sys_ctrl_mc (N_CH=2, GAP_W=4).
// Table-driven register vectors, hand-written soft-sync corner sequences, an optional
// timestamp sequence (SYS_CTRL_MC_TIMESTAMP_EN), then random traffic against a model.
module tb_sys_ctrl_mc;
    localparam int N_CH  = 2;
    localparam int GAP_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_b = 1'b0;
    logic [7:0]            err_flags;
    logic [3:0]            debug_modes;
    logic [N_CH*GAP_W-1:0] tx_sample_gap;
    logic [N_CH*2-1:0]     rx_sync_type;
    logic [N_CH*2-1:0]     tx_sync_type;
    logic [N_CH-1:0]       rx_sync;
    logic [N_CH-1:0]       tx_sync;
    logic                  sync_busy;

    sys_ctrl_mc_if bus ();

    sys_ctrl_mc #(.N_CH(N_CH), .GAP_W(GAP_W)) dut (
        .i_rst_b         (rst_b),
        .i_sys_clk       (clk),
        .bus             (bus),
        .i_err_flags     (err_flags),
        .o_debug_modes   (debug_modes),
        .o_tx_sample_gap (tx_sample_gap),
        .o_rx_sync_type  (rx_sync_type),
        .o_tx_sync_type  (tx_sync_type),
        .o_rx_sync       (rx_sync),
        .o_tx_sync       (tx_sync),
        .o_sync_busy     (sync_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_no = 0;

    // Reference model state, kept as plain per-field variables.
    logic [7:0]       m_dout, m_err, m_len, m_scratch;
    logic [3:0]       m_dbg;
    logic [1:0]       m_chsel;
    logic [GAP_W-1:0] m_gap [4];
    logic             m_rx09 [4], m_rx24 [4], m_tx09 [4], m_tx24 [4];
    logic             m_lvl [8];
    int               m_end [8];

    typedef struct {
        logic       cs;
        logic       fetch;
        logic       load;
        logic [4:0] ioc;
        logic [7:0] data;
        logic [7:0] err;
        logic       chk;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_dout = 8'h00; m_err = 8'h00; m_len = 8'h00; m_scratch = 8'h00;
        m_dbg = 4'h0; m_chsel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            m_gap[i] = '0; m_rx09[i] = 1'b0; m_rx24[i] = 1'b0; m_tx09[i] = 1'b0; m_tx24[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            m_lvl[i] = 1'b0; m_end[i] = 0;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [4:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            5'h00: r = 8'h02;
            5'h01: r = 8'h01;
            5'h02: r = 8'h01;
            5'h03: r = m_err;
            5'h05: r = {4'h0, m_dbg};
            5'h06: r = {6'h00, m_chsel};
            5'h07: if (int'(m_chsel) < N_CH)
                       r = {m_tx24[m_chsel], m_tx09[m_chsel], m_rx24[m_chsel], m_rx09[m_chsel], m_gap[m_chsel]};
            5'h09: r = m_len;
            5'h0A: r = m_scratch;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // A pulse triggered on edge E is high after edges E .. E+L-1.
    function automatic void model_sync_write(input int i, input logic b);
        if (m_len == 8'h00) begin
            m_lvl[i] = b; m_end[i] = 0;
        end else if (b) begin
            m_lvl[i] = 1'b0; m_end[i] = edge_no + int'(m_len);
        end
    endfunction

    function automatic logic model_sync(input int i);
        return m_lvl[i] | (edge_no < m_end[i]);
    endfunction

    function automatic void model_step(input logic cs, input logic f, input logic l,
                                       input logic [4:0] a, input logic [7:0] d, input logic [7:0] e);
        logic fe, ld;
        fe = cs && f;
        ld = cs && l && !f;
        if (fe) m_dout = model_read(a);
        if (fe && a == 5'h03) m_err = e;
        else                  m_err = m_err | e;
        if (ld) begin
            case (a)
                5'h05: m_dbg = d[3:0];
                5'h06: m_chsel = d[1:0];
                5'h07: if (int'(m_chsel) < N_CH) begin
                           m_gap[m_chsel] = d[GAP_W-1:0];
                           m_rx09[m_chsel] = d[4]; m_rx24[m_chsel] = d[5];
                           m_tx09[m_chsel] = d[6]; m_tx24[m_chsel] = d[7];
                       end
                5'h08: for (int c = 0; c < N_CH; c++) begin
                           model_sync_write(c, d[c]);
                           model_sync_write(4 + c, d[4 + c]);
                       end
                5'h09: m_len = d;
                5'h0A: m_scratch = d;
                default: ;
            endcase
        end
    endfunction

    // Drive one bus cycle at a falling edge; the model advances with the next rising edge.
    task automatic applyStimulus(input logic cs, input logic f, input logic l,
                                 input logic [4:0] a, input logic [7:0] d, input logic [7:0] e);
        bus.i_cs = cs; bus.i_fetch_cmd = f; bus.i_load_cmd = l;
        bus.i_ioc = a; bus.i_data_in = d; err_flags = e;
        edge_no++;
        model_step(cs, f, l, a, d, e);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 8'h00);
    endtask

    task automatic load_reg(input logic [4:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, 1'b1, a, d, 8'h00);
    endtask

    task automatic fetch_reg(input logic [4:0] a);
        applyStimulus(1'b1, 1'b1, 1'b0, a, 8'h00, 8'h00);
    endtask

    task automatic chk_sync(input string tag, input logic [1:0] er, input logic [1:0] et);
        checkOutput({tag, "_rx"}, 32'(rx_sync), 32'(er));
        checkOutput({tag, "_tx"}, 32'(tx_sync), 32'(et));
        checkOutput({tag, "_busy"}, 32'(sync_busy), 32'(|{er, et}));
    endtask

    task automatic check_all(input string tag);
        logic [N_CH*GAP_W-1:0] eg;
        logic [N_CH*2-1:0]     erxt, etxt;
        logic [N_CH-1:0]       erx, etx;
        for (int c = 0; c < N_CH; c++) begin
            eg[c*GAP_W +: GAP_W] = m_gap[c];
            erxt[2*c +: 2] = {m_rx24[c], m_rx09[c]};
            etxt[2*c +: 2] = {m_tx24[c], m_tx09[c]};
            erx[c] = model_sync(c);
            etx[c] = model_sync(4 + c);
        end
        checkOutput({tag, "_dout"}, 32'(bus.o_data_out), 32'(m_dout));
        checkOutput({tag, "_dbg"}, 32'(debug_modes), 32'(m_dbg));
        checkOutput({tag, "_gap"}, 32'(tx_sample_gap), 32'(eg));
        checkOutput({tag, "_rxtype"}, 32'(rx_sync_type), 32'(erxt));
        checkOutput({tag, "_txtype"}, 32'(tx_sync_type), 32'(etxt));
        checkOutput({tag, "_rxsync"}, 32'(rx_sync), 32'(erx));
        checkOutput({tag, "_txsync"}, 32'(tx_sync), 32'(etx));
        checkOutput({tag, "_busy"}, 32'(sync_busy), 32'(|{erx, etx}));
    endtask

    task automatic do_reset(input string tag);
        rst_b = 1'b0;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        bus.i_ioc = 5'h00; bus.i_data_in = 8'h00; err_flags = 8'h00;
        repeat (2) @(negedge clk);
        model_reset();
        check_all(tag);
        rst_b = 1'b1;
    endtask

    task automatic add_vec(input logic cs, input logic f, input logic l, input logic [4:0] a,
                           input logic [7:0] d, input logic [7:0] e, input logic chk, input logic [7:0] x);
        vec_t v;
        v.cs = cs; v.fetch = f; v.load = l; v.ioc = a; v.data = d; v.err = e; v.chk = chk; v.exp_rd = x;
        vecs.push_back(v);
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL timeout: got no finish, required finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [4:0] ld_addrs [8];
        logic       rcs, rf, rl;
        logic [4:0] ra;
        logic [7:0] rd, re;
        int         op, z_edge, f_edge;
        logic [31:0] snap;

        ld_addrs[0] = 5'h05; ld_addrs[1] = 5'h06; ld_addrs[2] = 5'h07; ld_addrs[3] = 5'h08;
        ld_addrs[4] = 5'h09; ld_addrs[5] = 5'h0A; ld_addrs[6] = 5'h04; ld_addrs[7] = 5'h01;

        // cs, fetch, load, ioc, data, err, chk, expected o_data_out
        add_vec(1, 1, 0, 5'h00, 8'h00, 8'h00, 1, 8'h02);
        add_vec(1, 1, 0, 5'h01, 8'h00, 8'h00, 1, 8'h01);
        add_vec(1, 1, 0, 5'h02, 8'h00, 8'h00, 1, 8'h01);
        add_vec(1, 1, 0, 5'h04, 8'h00, 8'h00, 1, 8'h00);
        add_vec(1, 0, 1, 5'h06, 8'h01, 8'h00, 0, 8'h00);
        add_vec(1, 0, 1, 5'h07, 8'hA5, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h07, 8'h00, 8'h00, 1, 8'hA5);
        add_vec(1, 1, 0, 5'h06, 8'h00, 8'h00, 1, 8'h01);
        add_vec(1, 0, 1, 5'h06, 8'h03, 8'h00, 0, 8'h00);
        add_vec(1, 0, 1, 5'h07, 8'hFF, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h07, 8'h00, 8'h00, 1, 8'h00);
        add_vec(1, 0, 1, 5'h06, 8'h01, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h07, 8'h00, 8'h00, 1, 8'hA5);
        add_vec(1, 0, 1, 5'h0A, 8'h5C, 8'h00, 0, 8'h00);
        add_vec(1, 1, 1, 5'h0A, 8'h33, 8'h00, 1, 8'h5C);
        add_vec(1, 1, 0, 5'h0A, 8'h00, 8'h00, 1, 8'h5C);
        add_vec(0, 0, 1, 5'h0A, 8'h77, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h0A, 8'h00, 8'h00, 1, 8'h5C);
        add_vec(1, 0, 1, 5'h05, 8'hFF, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h05, 8'h00, 8'h00, 1, 8'h0F);
        add_vec(1, 0, 1, 5'h09, 8'h07, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h09, 8'h00, 8'h00, 1, 8'h07);
        add_vec(1, 0, 1, 5'h09, 8'h00, 8'h00, 0, 8'h00);
        add_vec(0, 0, 0, 5'h00, 8'h00, 8'h04, 0, 8'h00);
        add_vec(1, 1, 0, 5'h03, 8'h00, 8'h00, 1, 8'h04);
        add_vec(1, 1, 0, 5'h03, 8'h00, 8'h00, 1, 8'h00);
        add_vec(0, 0, 0, 5'h00, 8'h00, 8'h02, 0, 8'h00);
        add_vec(1, 1, 0, 5'h03, 8'h00, 8'h01, 1, 8'h02);
        add_vec(1, 1, 0, 5'h03, 8'h00, 8'h00, 1, 8'h01);
        add_vec(1, 0, 1, 5'h01, 8'h55, 8'h00, 0, 8'h00);
        add_vec(1, 1, 0, 5'h01, 8'h00, 8'h00, 1, 8'h01);
        add_vec(1, 1, 0, 5'h08, 8'h00, 8'h00, 1, 8'h00);
`ifndef SYS_CTRL_MC_TIMESTAMP_EN
        add_vec(1, 1, 0, 5'h0A, 8'h00, 8'h00, 1, 8'h5C);
        add_vec(1, 1, 0, 5'h0C, 8'h00, 8'h00, 1, 8'h00);
        add_vec(1, 1, 0, 5'h0A, 8'h00, 8'h00, 1, 8'h5C);
        add_vec(1, 1, 0, 5'h0F, 8'h00, 8'h00, 1, 8'h00);
`endif

        do_reset("reset");

        $display("[TB] register vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cs, vecs[i].fetch, vecs[i].load, vecs[i].ioc, vecs[i].data, vecs[i].err);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d_rd", i), 32'(bus.o_data_out), 32'(vecs[i].exp_rd));
        end
        checkOutput("cfg_gap", 32'(tx_sample_gap), 32'h50);
        checkOutput("cfg_rxtype", 32'(rx_sync_type), 32'h8);
        checkOutput("cfg_txtype", 32'(tx_sync_type), 32'h8);
        checkOutput("cfg_dbg", 32'(debug_modes), 32'hF);

        $display("[TB] soft-sync sequences");
        load_reg(5'h09, 8'd3);
        load_reg(5'h08, 8'h01); chk_sync("pulse_c1", 2'b01, 2'b00);
        idle();                 chk_sync("pulse_c2", 2'b01, 2'b00);
        idle();                 chk_sync("pulse_c3", 2'b01, 2'b00);
        idle();                 chk_sync("pulse_end", 2'b00, 2'b00);
        idle();                 chk_sync("pulse_low", 2'b00, 2'b00);

        load_reg(5'h08, 8'h01); chk_sync("retrig_c1", 2'b01, 2'b00);
        idle();                 chk_sync("retrig_c2", 2'b01, 2'b00);
        load_reg(5'h08, 8'h01); chk_sync("retrig_c3", 2'b01, 2'b00);
        idle();                 chk_sync("retrig_c4", 2'b01, 2'b00);
        idle();                 chk_sync("retrig_c5", 2'b01, 2'b00);
        idle();                 chk_sync("retrig_end", 2'b00, 2'b00);

        load_reg(5'h08, 8'h20); chk_sync("tx1_c1", 2'b00, 2'b10);
        load_reg(5'h08, 8'h00); chk_sync("zero_nocut", 2'b00, 2'b10);
        idle();                 chk_sync("tx1_c3", 2'b00, 2'b10);
        idle();                 chk_sync("tx1_end", 2'b00, 2'b00);

        load_reg(5'h09, 8'd0);
        load_reg(5'h08, 8'h12); chk_sync("level_set", 2'b10, 2'b01);
        repeat (3) idle();      chk_sync("level_hold", 2'b10, 2'b01);
        load_reg(5'h08, 8'h00); chk_sync("level_clr", 2'b00, 2'b00);

        load_reg(5'h09, 8'd4);
        load_reg(5'h08, 8'h01); chk_sync("freeze_c1", 2'b01, 2'b00);
        idle();
        load_reg(5'h09, 8'd0);  chk_sync("freeze_len0", 2'b01, 2'b00);
        repeat (5) idle();      chk_sync("freeze_hold", 2'b01, 2'b00);
        load_reg(5'h08, 8'h00); chk_sync("freeze_rel", 2'b00, 2'b00);

        load_reg(5'h09, 8'd5);
        load_reg(5'h08, 8'h11); chk_sync("arst_pre", 2'b01, 2'b01);
        #2 rst_b = 1'b0;
        #1 checkOutput("arst_rx", 32'(rx_sync), 32'h0);
        checkOutput("arst_tx", 32'(tx_sync), 32'h0);
        checkOutput("arst_busy", 32'(sync_busy), 32'h0);
        @(negedge clk);
        do_reset("arst_state");

`ifdef SYS_CTRL_MC_TIMESTAMP_EN
        $display("[TB] timestamp sequence");
        load_reg(5'h0C, 8'h00);
        z_edge = edge_no;
        repeat (400) idle();
        fetch_reg(5'h0C);
        f_edge = edge_no;
        snap = 32'(f_edge - z_edge - 1);
        checkOutput("ts_b0", 32'(bus.o_data_out), 32'(snap[7:0]));
        repeat (300) idle();
        fetch_reg(5'h0D); checkOutput("ts_b1", 32'(bus.o_data_out), 32'(snap[15:8]));
        fetch_reg(5'h0E); checkOutput("ts_b2", 32'(bus.o_data_out), 32'(snap[23:16]));
        fetch_reg(5'h0F); checkOutput("ts_b3", 32'(bus.o_data_out), 32'(snap[31:24]));
        load_reg(5'h0C, 8'h00);
        z_edge = edge_no;
        fetch_reg(5'h0C); checkOutput("ts_restart", 32'(bus.o_data_out), 32'h0);
        repeat (4) idle();
        fetch_reg(5'h0C);
        snap = 32'(edge_no - z_edge - 1);
        checkOutput("ts_count", 32'(bus.o_data_out), 32'(snap[7:0]));
        do_reset("ts_reset");
`endif

        $display("[TB] random traffic");
        for (int it = 0; it < 800; it++) begin
            rcs = ($urandom_range(0, 7) != 0);
            op  = int'($urandom_range(0, 9));
            rf  = (op < 4);
            rl  = (op >= 4) || (op == 0);
            rd  = 8'($urandom_range(0, 255));
            if (rf && rl) begin
                ra = 5'($urandom_range(0, 11));
            end else if (rf) begin
`ifdef SYS_CTRL_MC_TIMESTAMP_EN
                ra = 5'($urandom_range(0, 11));
`else
                ra = 5'($urandom_range(0, 31));
`endif
            end else begin
                ra = ld_addrs[$urandom_range(0, 7)];
            end
            if (ra == 5'h09) rd = 8'($urandom_range(1, 6));
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            applyStimulus(rcs, rf, rl, ra, rd, re);
            check_all($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
